// File: rtl/issue_sched.sv
// Dual-issue scheduler for a two-entry issue buffer head.
// Decides how many head entries to pop, routes them to EX pipes A/B, and
// tracks load-use stalls, flush dead cycles and issue/bubble statistics.
module issue_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  head_valid,
  input  logic [4:0]  i0_rd,
  input  logic [4:0]  i0_rj,
  input  logic [4:0]  i0_rk,
  input  logic [4:0]  i1_rd,
  input  logic [4:0]  i1_rj,
  input  logic [4:0]  i1_rk,
  input  logic        i0_we,
  input  logic        i1_we,
  input  logic        i0_mem,
  input  logic        i1_mem,
  input  logic        i0_br,
  input  logic        i1_br,
  input  logic [4:0]  ex_a_rd,
  input  logic [4:0]  ex_b_rd,
  input  logic        ex_a_ld,
  input  logic        ex_b_ld,
  input  logic        flush_br,
  input  logic        stall_dcache,
  output logic [1:0]  pop_cnt,
  output logic        issue_a_valid,
  output logic        issue_b_valid,
  output logic        issue_swap,
  output logic [31:0] issue_cnt,
  output logic [31:0] bubble_cnt
);

  localparam int unsigned CntW = 32;
  localparam int unsigned RegW = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   issue_cnt_q, issue_cnt_d;
  logic [CntW-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic              bubble;

  logic hv0, hv1;
  logic i0_lu, i1_lu;
  logic raw_01, waw_01;
  logic dual_ok;

  // Source register r waits on a load still in EX; x0 never waits.
  function automatic logic lu_hit(input logic [RegW-1:0] r,
                                  input logic [RegW-1:0] a_rd, input logic a_ld,
                                  input logic [RegW-1:0] b_rd, input logic b_ld);
    return (r != RegW'(0)) && ((a_ld && (r == a_rd)) || (b_ld && (r == b_rd)));
  endfunction

  // Entry 1 alone is meaningless, so it only counts behind a valid entry 0.
  assign hv0 = head_valid[0];
  assign hv1 = head_valid[0] & head_valid[1];

  assign i0_lu = lu_hit(i0_rj, ex_a_rd, ex_a_ld, ex_b_rd, ex_b_ld)
               | lu_hit(i0_rk, ex_a_rd, ex_a_ld, ex_b_rd, ex_b_ld);
  assign i1_lu = lu_hit(i1_rj, ex_a_rd, ex_a_ld, ex_b_rd, ex_b_ld)
               | lu_hit(i1_rk, ex_a_rd, ex_a_ld, ex_b_rd, ex_b_ld);

  // Intra-pair dependencies that forbid issuing both entries together.
  assign raw_01 = i0_we && (i0_rd != RegW'(0)) && ((i1_rj == i0_rd) || (i1_rk == i0_rd));
  assign waw_01 = i0_we && i1_we && (i0_rd != RegW'(0)) && (i0_rd == i1_rd);

  assign dual_ok = hv1 && !i0_lu && !i1_lu && !raw_01 && !waw_01
                && !(i0_mem && i1_mem) && !(i0_br && i1_br);

  // Issue decision, next state and counter updates.
  always_comb begin
    state_d       = state_q;
    pop_cnt       = 2'd0;
    issue_a_valid = 1'b0;
    issue_b_valid = 1'b0;
    issue_swap    = 1'b0;
    bubble        = 1'b0;
    issue_cnt_d   = issue_cnt_q;
    bubble_cnt_d  = bubble_cnt_q;

    if (rst) begin
      state_d = RUN;
    end else if (flush_br) begin
      state_d = FLUSH;
    end else if (!stall_dcache) begin
      case (state_q)
        RUN: begin
          if (hv0) begin
            if (i0_lu) begin
              state_d = LU_WAIT;
              bubble  = 1'b1;
            end else if (dual_ok) begin
              pop_cnt       = 2'd2;
              issue_a_valid = 1'b1;
              issue_b_valid = 1'b1;
              issue_swap    = i0_mem | i1_br;
            end else begin
              pop_cnt = 2'd1;
              bubble  = hv1;
              if (i0_mem) begin
                issue_b_valid = 1'b1;
                issue_swap    = 1'b1;
              end else begin
                issue_a_valid = 1'b1;
              end
            end
          end
        end
        LU_WAIT: begin
          state_d = RUN;
          bubble  = hv0;
        end
        default: state_d = RUN;
      endcase
      issue_cnt_d  = issue_cnt_q + CntW'(pop_cnt);
      bubble_cnt_d = bubble_cnt_q + CntW'(bubble);
    end
  end

  // State and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      issue_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign issue_cnt  = issue_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
